// File: rtl/uart_rx_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_packer_if
// Purpose  : AXI-Stream style bundle (data, keep, user, last, valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_word_packer_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata, tkeep, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tlast, tvalid,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_packer
// Purpose  : Packs UART bytes little-endian into 32-bit stream words, with
//            partial-word emission on idle timeout or flush.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_packer #(
  parameter int IDLE_TIMEOUT = 1024,
  parameter bit DROP_ERRORS  = 1'b0
) (
  input  wire logic              aclk,
  input  wire logic              aresetn,
  input  wire logic              flush,
  uart_rx_word_packer_if.slave   s_axis,
  uart_rx_word_packer_if.master  m_axis
);

  localparam bit TIMEOUT_EN = (IDLE_TIMEOUT > 0);
  localparam int TIMER_W    = TIMEOUT_EN ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
      TIMER_W'(TIMEOUT_EN ? IDLE_TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [31:0]        acc, acc_next;
  logic [3:0]         keep, keep_next;
  logic               err, err_next;
  logic [1:0]         idx, idx_next;
  logic [TIMER_W-1:0] timer, timer_next;

  logic [31:0]        out_data, out_data_next;
  logic [3:0]         out_keep, out_keep_next;
  logic               out_user, out_user_next;
  logic               out_last, out_last_next;
  logic               out_valid, out_valid_next;

  logic               s_ready;
  logic               accept;
  logic               drop;
  logic               take;
  logic               timeout_hit;
  logic               flush_hit;
  logic               unused_bits;

  assign s_ready = (state == FILL) && aresetn;
  assign accept  = s_axis.tvalid && s_ready;
  assign drop    = DROP_ERRORS && s_axis.tuser;
  assign take    = accept && !drop;

  // Any accepted byte (even a dropped one) suppresses the timeout that cycle.
  assign timeout_hit = TIMEOUT_EN && (state == FILL) && !accept &&
                       (idx != 2'd0) && (timer == TIMER_LAST);

  assign unused_bits = ^{s_axis.tdata[15:8], s_axis.tkeep, s_axis.tlast};

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;
  assign m_axis.tvalid = out_valid;

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    keep_next      = keep;
    err_next       = err;
    idx_next       = idx;
    timer_next     = timer;
    out_data_next  = out_data;
    out_keep_next  = out_keep;
    out_user_next  = out_user;
    out_last_next  = out_last;
    out_valid_next = out_valid;
    flush_hit      = 1'b0;

    case (state)
      FILL: begin
        if (take) begin
          acc_next[{idx, 3'b000} +: 8] = s_axis.tdata[7:0];
          keep_next[idx]               = 1'b1;
          err_next                     = err | s_axis.tuser;
          idx_next                     = idx + 2'd1;
          timer_next                   = '0;
        end else if (TIMEOUT_EN && !accept && (idx != 2'd0)) begin
          timer_next = timer + TIMER_W'(1);
        end

        // Flush looks at the lanes after this cycle's byte, so a byte
        // arriving with flush is included in the emitted word.
        flush_hit = flush && (keep_next != 4'h0);

        if ((take && (idx == 2'd3)) || flush_hit || timeout_hit) begin
          out_data_next  = acc_next;
          out_keep_next  = keep_next;
          out_user_next  = err_next;
          out_last_next  = flush_hit || timeout_hit;
          out_valid_next = 1'b1;
          state_next     = OUT;
        end
      end

      OUT: begin
        if (m_axis.tready) begin
          out_valid_next = 1'b0;
          acc_next       = '0;
          keep_next      = '0;
          err_next       = 1'b0;
          idx_next       = '0;
          timer_next     = '0;
          state_next     = FILL;
        end
      end

      default: begin
        state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= FILL;
      acc       <= '0;
      keep      <= '0;
      err       <= 1'b0;
      idx       <= '0;
      timer     <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      keep      <= keep_next;
      err       <= err_next;
      idx       <= idx_next;
      timer     <= timer_next;
      out_data  <= out_data_next;
      out_keep  <= out_keep_next;
      out_user  <= out_user_next;
      out_last  <= out_last_next;
      out_valid <= out_valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_word_packer
// Purpose  : Vector table, directed corner sequences and random stimulus
//            against a queue-based word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word_packer;

  localparam int TO = 16;
  localparam logic [39:0] IDLE_E = {1'b1, 1'b0, 38'b0};

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic flush0  = 1'b0;
  logic flush1  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 aclk = ~aclk;

  uart_rx_word_packer_if #(.DATA_W(16), .KEEP_W(2)) s0 (), s1 ();
  uart_rx_word_packer_if #(.DATA_W(32), .KEEP_W(4)) m0 (), m1 ();

  uart_rx_word_packer #(.IDLE_TIMEOUT(TO), .DROP_ERRORS(1'b0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .flush(flush0),
    .s_axis(s0.slave), .m_axis(m0.master)
  );

  uart_rx_word_packer #(.IDLE_TIMEOUT(TO), .DROP_ERRORS(1'b1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .flush(flush1),
    .s_axis(s1.slave), .m_axis(m1.master)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        u;
    logic        fl;
    logic        mr;
    logic [39:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: bytes of the word being built, plus the pending word.
  logic [8:0]  cur[$];
  int          idle;
  bit          busy;
  logic [31:0] w_data;
  logic [3:0]  w_keep;
  bit          w_user;
  bit          w_last;

  function automatic logic [39:0] pack(bit rdy, bit vld, logic [31:0] d,
                                       logic [3:0] k, bit u, bit l);
    return {rdy, vld, d, k, u, l};
  endfunction

  task automatic check(string name, logic [39:0] got, logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Payload fields only matter while a word is expected to be valid.
  task automatic check0(string name, logic [39:0] exp);
    logic [39:0] got;
    got = pack(s0.tready, m0.tvalid, m0.tdata, m0.tkeep, m0.tuser, m0.tlast);
    if (!exp[38]) got[37:0] = '0;
    check(name, got, exp);
  endtask

  task automatic check1(string name, logic [39:0] exp);
    logic [39:0] got;
    got = pack(s1.tready, m1.tvalid, m1.tdata, m1.tkeep, m1.tuser, m1.tlast);
    if (!exp[38]) got[37:0] = '0;
    check(name, got, exp);
  endtask

  task automatic step0(bit rstn, bit v, logic [15:0] d, bit u, bit fl, bit mr);
    aresetn   = rstn;
    s0.tvalid = v;
    s0.tdata  = d;
    s0.tuser  = u;
    flush0    = fl;
    m0.tready = mr;
    @(posedge aclk);
    #1;
  endtask

  task automatic step1(bit v, logic [15:0] d, bit u);
    s1.tvalid = v;
    s1.tdata  = d;
    s1.tuser  = u;
    @(posedge aclk);
    #1;
  endtask

  task automatic add(bit v, logic [15:0] d, bit u, bit fl, bit mr, logic [39:0] e);
    vec_t r;
    r.v = v; r.d = d; r.u = u; r.fl = fl; r.mr = mr; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic model_step(bit rstn, bit v, logic [7:0] d, bit u, bit fl, bit mr);
    bit closing;
    if (!rstn) begin
      busy = 1'b0;
      cur.delete();
      idle = 0;
    end else if (busy) begin
      if (mr) begin
        busy = 1'b0;
        cur.delete();
        idle = 0;
      end
    end else begin
      closing = 1'b0;
      w_last  = 1'b0;
      if (v) begin
        cur.push_back({u, d});
        idle = 0;
      end
      if (cur.size() == 4) closing = 1'b1;
      if (fl && cur.size() > 0) begin
        closing = 1'b1;
        w_last  = 1'b1;
      end
      if (!v && cur.size() > 0) begin
        if (idle == TO - 1) begin
          closing = 1'b1;
          w_last  = 1'b1;
        end else begin
          idle++;
        end
      end
      if (closing) begin
        w_data = '0;
        w_user = 1'b0;
        for (int i = 0; i < cur.size(); i++) begin
          w_data = w_data | (32'(cur[i][7:0]) << (8 * i));
          w_user = w_user | cur[i][8];
        end
        w_keep = 4'((1 << cur.size()) - 1);
        busy   = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    s0.tvalid = 1'b0; s0.tdata = '0; s0.tuser = 1'b0; s0.tkeep = '1; s0.tlast = 1'b0;
    s1.tvalid = 1'b0; s1.tdata = '0; s1.tuser = 1'b0; s1.tkeep = '1; s1.tlast = 1'b0;
    m0.tready = 1'b1;
    m1.tready = 1'b1;

    // Reset state
    step0(0, 0, 0, 0, 0, 1);
    step0(0, 0, 0, 0, 0, 1);
    check("reset_dut0", pack(s0.tready, m0.tvalid, m0.tdata, m0.tkeep, m0.tuser, m0.tlast), 40'b0);
    check("reset_dut1", pack(s1.tready, m1.tvalid, m1.tdata, m1.tkeep, m1.tuser, m1.tlast), 40'b0);

    // Full word; upper tdata bits ignored
    add(1, 16'hAB11, 0, 0, 1, IDLE_E);
    add(1, 16'hCD22, 0, 0, 1, IDLE_E);
    add(1, 16'h0033, 0, 0, 1, IDLE_E);
    add(1, 16'hFF44, 0, 0, 1, pack(0, 1, 32'h44332211, 4'hF, 0, 0));
    add(0, 16'h0000, 0, 0, 1, IDLE_E);
    // Parity error propagates, word held under backpressure
    add(1, 16'h005A, 1, 0, 0, IDLE_E);
    add(1, 16'h0001, 0, 0, 0, IDLE_E);
    add(1, 16'h0002, 0, 0, 0, IDLE_E);
    add(1, 16'h0003, 0, 0, 0, pack(0, 1, 32'h0302015A, 4'hF, 1, 0));
    add(0, 16'h0000, 0, 0, 0, pack(0, 1, 32'h0302015A, 4'hF, 1, 0));
    add(0, 16'h0000, 0, 0, 1, IDLE_E);
    // Flush on empty accumulator, then flush with the 3rd byte
    add(0, 16'h0000, 0, 1, 1, IDLE_E);
    add(0, 16'h0000, 0, 0, 1, IDLE_E);
    add(1, 16'h0077, 0, 0, 0, IDLE_E);
    add(1, 16'h0088, 0, 0, 0, IDLE_E);
    add(1, 16'h0099, 0, 1, 0, pack(0, 1, 32'h00998877, 4'h7, 0, 1));
    add(0, 16'h0000, 0, 1, 0, pack(0, 1, 32'h00998877, 4'h7, 0, 1));
    add(0, 16'h0000, 0, 0, 1, IDLE_E);
    add(0, 16'h0000, 0, 0, 1, IDLE_E);
    // Flush with the 4th byte closes as last
    add(1, 16'h00A1, 0, 0, 0, IDLE_E);
    add(1, 16'h00A2, 0, 0, 0, IDLE_E);
    add(1, 16'h00A3, 0, 0, 0, IDLE_E);
    add(1, 16'h00A4, 0, 1, 0, pack(0, 1, 32'hA4A3A2A1, 4'hF, 0, 1));
    add(0, 16'h0000, 0, 0, 1, IDLE_E);

    for (int i = 0; i < tbl.size(); i++) begin
      step0(1, tbl[i].v, tbl[i].d, tbl[i].u, tbl[i].fl, tbl[i].mr);
      check0($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Idle timeout on a 2-byte partial word
    step0(1, 1, 16'h00AA, 0, 0, 0);
    step0(1, 1, 16'h00BB, 0, 0, 0);
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step0(1, 0, 0, 0, 0, 0);
      if (m0.tvalid) begin
        seen = 1'b1;
        n = k;
      end
    end
    check("timeout_cycles", 40'(n), 40'd16);
    check0("timeout_word", pack(0, 1, 32'h0000BBAA, 4'h3, 0, 1));
    step0(1, 0, 0, 0, 0, 1);
    check0("timeout_release", IDLE_E);

    // Long backpressure with a byte waiting at the input
    step0(1, 1, 16'h0010, 0, 0, 0);
    step0(1, 1, 16'h0020, 0, 0, 0);
    step0(1, 1, 16'h0030, 0, 0, 0);
    step0(1, 1, 16'h0040, 0, 0, 0);
    for (int k = 0; k < 50; k++) begin
      step0(1, 1, 16'h0066, 0, 0, 0);
      check0("hold", pack(0, 1, 32'h40302010, 4'hF, 0, 0));
    end
    step0(1, 1, 16'h0066, 0, 0, 1);
    check0("hold_release", IDLE_E);
    step0(1, 1, 16'h0066, 0, 0, 1);
    step0(1, 1, 16'h0067, 0, 0, 1);
    step0(1, 1, 16'h0068, 0, 0, 1);
    step0(1, 1, 16'h0069, 0, 0, 0);
    check0("after_hold_word", pack(0, 1, 32'h69686766, 4'hF, 0, 0));
    step0(1, 0, 0, 0, 0, 1);

    // Reset mid-word
    step0(1, 1, 16'h00E1, 0, 0, 1);
    step0(1, 1, 16'h00E2, 0, 0, 1);
    step0(0, 0, 0, 0, 0, 1);
    check("reset_mid", pack(s0.tready, m0.tvalid, m0.tdata, m0.tkeep, m0.tuser, m0.tlast), 40'b0);
    step0(1, 1, 16'h00C1, 0, 0, 0);
    step0(1, 1, 16'h00C2, 0, 0, 0);
    step0(1, 1, 16'h00C3, 0, 0, 0);
    step0(1, 1, 16'h00C4, 0, 0, 0);
    check0("post_reset_word", pack(0, 1, 32'hC4C3C2C1, 4'hF, 0, 0));
    step0(1, 0, 0, 0, 0, 1);

    // Errored byte discarded when dropping is enabled
    step1(1, 16'h005A, 1);
    step1(1, 16'h0001, 0);
    step1(1, 16'h0002, 0);
    step1(1, 16'h0003, 0);
    check1("drop_partial", IDLE_E);
    step1(1, 16'h0004, 0);
    check1("drop_word", pack(0, 1, 32'h04030201, 4'hF, 0, 0));
    step1(0, 16'h0000, 0);
    check1("drop_release", IDLE_E);

    // Random traffic against the model
    busy = 1'b0;
    cur.delete();
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      bit rstn, v, u, fl, mr;
      int p;
      logic [15:0] d;
      rstn = !(c == 0 || $urandom_range(0, 299) == 0);
      p    = ((c % 80) < 30) ? 70 : 3;
      v    = ($urandom_range(0, 99) < p);
      d    = 16'($urandom);
      u    = ($urandom_range(0, 7) == 0);
      fl   = ($urandom_range(0, 29) == 0);
      mr   = ($urandom_range(0, 2) != 0);
      step0(rstn, v, d, u, fl, mr);
      model_step(rstn, v, d[7:0], u, fl, mr);
      check0($sformatf("rand%0d", c),
             pack(rstn && !busy, busy, busy ? w_data : 32'h0,
                  busy ? w_keep : 4'h0, busy && w_user, busy && w_last));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
